rlbp_stream_rx: RTL and testbench

Receive-side counterpart of the rLBP sequencer's serial result output. Samples the sequencer's bit clock, start, data and done lines in the Wishbone clock domain, deserializes each frame of LBP codes MSB-first into 32-bit words, and buffers them in a small FIFO. The management SoC drains the FIFO over Wishbone. The block sits inside the user project wrapper beside the rLBP macro.

---
 rtl/rlbp_rx_pkg.sv | 24 ++
 rtl/rlbp_rx_fifo.sv | 68 ++++++
 rtl/rlbp_stream_rx.sv | 186 ++++++++++++++++++
 tb/tb_rlbp_stream_rx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rlbp_rx_pkg.sv
// Shared definitions for the rLBP serial result receiver.
// Register offsets, STATUS/CTRL bit positions and the receive FSM states.
package rlbp_rx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;
  localparam logic [3:0] REG_FRAMES = 4'hC;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 16;
  localparam int ST_FERR  = 17;
  localparam int ST_BUSY  = 18;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/rlbp_rx_fifo.sv
// Synchronous word FIFO: pop data is the head word combinationally, level updates one cycle after push/pop.
// A push while full is only accepted when a pop happens in the same cycle; otherwise the word is ignored.
module rlbp_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign level   = cnt_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rlbp_stream_rx.sv
// Deserializes rLBP sequencer frames (MSB-first, 32-bit words) into a FIFO drained over Wishbone.
// Bit reaches the shift register 3 cycles after a bit_clk rise; FIFO overflow drops the word and sets ovf.
module rlbp_stream_rx
  import rlbp_rx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
  parameter int          FRAME_BITS = 96,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        bit_clk_i,
  input  logic        start_i,
  input  logic        data_i,
  input  logic        done_i,
  output logic        irq_o
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_BITS);

  logic [3:0]    meta_q, meta_d, sync_q, sync_d;
  logic          bclk_prev_q, bclk_prev_d;
  rx_state_e     state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_q, push_d;
  logic          ack_q, ack_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          ovf_q, ovf_d, ferr_q, ferr_d;
  logic [15:0]   frames_q, frames_d;

  logic          s_start, s_data, s_done, bit_evt;
  logic          addr_sel, rd_acc, wr_acc, wr_ctrl, wr_status, en_now;
  logic          fifo_pop, fifo_empty, fifo_full, ovf_set, ferr_set, frame_inc;
  logic [31:0]   fifo_dat, status, rd_dat;
  logic [LW-1:0] fifo_level;
  logic [3:0]    off;
  logic          unused_dat;

  assign unused_dat = ^wbs_dat_i;

  // Synchronizer order: {bit_clk, start, data, done}.
  assign s_start = sync_q[2];
  assign s_data  = sync_q[1];
  assign s_done  = sync_q[0];
  assign bit_evt = sync_q[3] & ~bclk_prev_q;

  assign off       = wbs_adr_i[3:0];
  assign addr_sel  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign rd_acc    = ack_q & ~wbs_we_i;
  assign wr_acc    = ack_q & wbs_we_i;
  assign wr_ctrl   = wr_acc & (off == REG_CTRL);
  assign wr_status = wr_acc & (off == REG_STATUS);
  assign fifo_pop  = rd_acc & (off == REG_DATA);
  assign en_now    = wr_ctrl ? wbs_dat_i[CTRL_EN] : ctrl_q[CTRL_EN];
  assign ovf_set   = push_q & fifo_full & ~fifo_pop;

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rd_acc ? rd_dat : 32'd0;
  assign irq_o     = ctrl_q[CTRL_IRQ_EN] & (~fifo_empty | ovf_q | ferr_q);

  rlbp_rx_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .push     (push_q),
    .push_dat (shift_q),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .level    (fifo_level),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    meta_d      = {bit_clk_i, start_i, data_i, done_i};
    sync_d      = meta_q;
    bclk_prev_d = sync_q[3];
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    push_d      = 1'b0;
    ferr_set    = 1'b0;
    frame_inc   = 1'b0;
    if (bit_evt) begin
      case (state_q)
        ST_IDLE: begin
          if (en_now && s_start) begin
            shift_d = {31'd0, s_data};
            cnt_d   = CW'(1);
            state_d = ST_RECV;
          end
        end
        ST_RECV: begin
          if (s_start) begin
            ferr_set = 1'b1;
            shift_d  = {31'd0, s_data};
            cnt_d    = CW'(1);
          end else begin
            shift_d = {shift_q[30:0], s_data};
            cnt_d   = cnt_q + CW'(1);
            push_d  = (cnt_d[4:0] == 5'd0);
            if (s_done) begin
              if (cnt_d == FRAME_CNT) frame_inc = 1'b1;
              else                    ferr_set  = 1'b1;
              state_d = ST_IDLE;
            end else if (cnt_d == FRAME_CNT) begin
              ferr_set = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Disabling abandons the frame in progress; its partial word never reaches the FIFO.
    if (!en_now) state_d = ST_IDLE;
  end

  always_comb begin
    ack_d  = wbs_cyc_i & wbs_stb_i & ~ack_q & addr_sel;
    ctrl_d = wr_ctrl ? wbs_dat_i[1:0] : ctrl_q;
    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    if (wr_status && wbs_dat_i[ST_OVF])  ovf_d  = 1'b0;
    if (wr_status && wbs_dat_i[ST_FERR]) ferr_d = 1'b0;
    if (ovf_set)  ovf_d  = 1'b1;
    if (ferr_set) ferr_d = 1'b1;
    frames_d = frames_q + {15'd0, frame_inc};
  end

  always_comb begin
    status           = 32'd0;
    status[3:0]      = 4'(fifo_level);
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = ovf_q;
    status[ST_FERR]  = ferr_q;
    status[ST_BUSY]  = (state_q == ST_RECV);
    case (off)
      REG_DATA:   rd_dat = fifo_empty ? 32'd0 : fifo_dat;
      REG_STATUS: rd_dat = status;
      REG_CTRL:   rd_dat = {30'd0, ctrl_q};
      REG_FRAMES: rd_dat = {16'd0, frames_q};
      default:    rd_dat = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      meta_q      <= '0;
      sync_q      <= '0;
      bclk_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      push_q      <= 1'b0;
      ack_q       <= 1'b0;
      ctrl_q      <= '0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
      frames_q    <= '0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      bclk_prev_q <= bclk_prev_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      push_q      <= push_d;
      ack_q       <= ack_d;
      ctrl_q      <= ctrl_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_rlbp_stream_rx.sv
// Scoreboarded bench for rlbp_stream_rx: frames are driven bit by bit, a reference model predicts
// FIFO words and status flags, and a monitor compares every Wishbone read against the prediction.
module tb_rlbp_stream_rx;
  localparam logic [31:0] BASE = 32'h3000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        bclk, start, data, done;
  logic        irq;

  always #5 clk = ~clk;

  rlbp_stream_rx dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .bit_clk_i (bclk),
    .start_i   (start),
    .data_i    (data),
    .done_i    (done),
    .irq_o     (irq)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  // Reference model state
  logic [31:0] m_fifo[$];
  bit          m_ovf, m_ferr, m_en, m_irqen, m_infr;
  int          m_frames;
  bit          frame_bits[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  string       mon_nm;
  logic [31:0] mon_exp;
  always @(negedge clk) begin
    if (ack && !we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got %h expected no read ack", rdat);
      end else begin
        mon_nm  = name_q.pop_front();
        mon_exp = exp_q.pop_front();
        check(mon_nm, rdat, mon_exp);
      end
    end
  end

  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL wb_ack_timeout: got no ack expected ack within 8 cycles (adr %h)", a);
      if (!w && exp_q.size() > 0) begin
        void'(exp_q.pop_back());
        void'(name_q.pop_back());
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    wb_xfer(1'b0, a, 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    wb_xfer(1'b1, a, d);
  endtask

  function automatic logic [31:0] status_exp(input bit busy);
    logic [31:0] s = 32'd0;
    int lvl = m_fifo.size();
    s[3:0] = 4'(lvl);
    s[8]   = (lvl == 0);
    s[9]   = (lvl == 8);
    s[16]  = m_ovf;
    s[17]  = m_ferr;
    s[18]  = busy;
    return s;
  endfunction

  function automatic logic [31:0] m_pop();
    if (m_fifo.size() == 0) return 32'd0;
    return m_fifo.pop_front();
  endfunction

  function automatic void m_push(input logic [31:0] w);
    if (m_fifo.size() == 8) m_ovf = 1'b1;
    else                    m_fifo.push_back(w);
  endfunction

  // Bits [last-31 .. last] of the frame, first-sent bit as the word MSB.
  function automatic logic [31:0] word_ending_at(input int last);
    logic [31:0] w = 32'd0;
    for (int k = 0; k < 32; k++) w[31-k] = frame_bits[last-31+k];
    return w;
  endfunction

  function automatic void m_reset();
    m_fifo.delete();
    m_ovf = 0; m_ferr = 0; m_en = 0; m_irqen = 0; m_infr = 0; m_frames = 0;
  endfunction

  task automatic fill_random();
    frame_bits.delete();
    for (int k = 0; k < 96; k++) frame_bits.push_back(1'($urandom_range(0, 1)));
  endtask

  // act: 0 none, 1 DATA read acked in the push cycle of this bit, 2 STATUS read after this bit,
  // 3 reset after this bit (frame abandoned)
  task automatic send_frame(input int len, input bit with_done, input int act, input int act_bit);
    logic [31:0] e;
    for (int i = 0; i < len; i++) begin
      data  = frame_bits[i];
      start = (i == 0);
      done  = with_done && (i == len - 1);
      repeat (3) begin @(posedge clk); #1; end
      bclk = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      if (act == 1 && i == act_bit) begin
        e = m_pop();
        exp_q.push_back(e);
        name_q.push_back("data_same_cycle");
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE;
      end
      @(posedge clk); #1; @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      bclk = 1'b0;
      if (m_en) begin
        if (i == 0) begin
          if (m_infr) m_ferr = 1'b1;
          m_infr = 1'b1;
        end
        if (m_infr) begin
          if ((i + 1) % 32 == 0) m_push(word_ending_at(i));
          if (with_done && i == len - 1) begin
            if (i + 1 == 96) m_frames++;
            else             m_ferr = 1'b1;
            m_infr = 1'b0;
          end else if (i + 1 == 96) begin
            m_ferr = 1'b1;
            m_infr = 1'b0;
          end
        end
      end
      if (act == 2 && i == act_bit) wb_read(BASE + 4, status_exp(m_infr), "status_mid_frame");
      if (act == 3 && i == act_bit) begin
        check("irq_before_reset", 32'(irq),
              32'(m_irqen && (m_fifo.size() > 0 || m_ovf || m_ferr)));
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("ack_in_reset", 32'(ack), 32'd0);
        check("dat_in_reset", rdat, 32'd0);
        check("irq_in_reset", 32'(irq), 32'd0);
        rst = 1'b0;
        m_reset();
        start = 1'b0; data = 1'b0; done = 1'b0;
        return;
      end
    end
    start = 1'b0; data = 1'b0; done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    bclk = 1'b0; start = 1'b0; data = 1'b0; done = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("ack_reset", 32'(ack), 32'd0);
    check("dat_reset", rdat, 32'd0);
    check("irq_reset", 32'(irq), 32'd0);
    rst = 1'b0;
    wb_read(BASE + 4,  status_exp(0), "status_reset");
    wb_read(BASE + 8,  32'd0, "ctrl_reset");
    wb_read(BASE + 12, 32'd0, "frames_reset");

    wb_write(BASE + 8, 32'd1); m_en = 1'b1;
    wb_read(BASE + 8, 32'd1, "ctrl_readback");

    // Clean frame carrying codes 0x01..0x0C
    frame_bits.delete();
    for (int b = 1; b <= 12; b++)
      for (int k = 7; k >= 0; k--) frame_bits.push_back(1'((b >> k) & 1));
    send_frame(96, 1'b1, 2, 20);
    wb_read(BASE + 4,  status_exp(0), "status_clean");
    wb_read(BASE + 12, 32'(m_frames), "frames_clean");
    repeat (3) wb_read(BASE, m_pop(), "data_clean");
    wb_read(BASE + 4, status_exp(0), "status_drained");

    // done at bit 40
    fill_random();
    send_frame(40, 1'b1, 0, 0);
    wb_read(BASE + 4,  status_exp(0), "status_short");
    wb_read(BASE + 12, 32'(m_frames), "frames_short");
    wb_write(BASE + 4, 32'h0002_0000); m_ferr = 1'b0;
    wb_read(BASE + 4, status_exp(0), "status_ferr_clear");
    wb_read(BASE, m_pop(), "data_short");

    // Restart mid-frame, then a frame that runs out without done
    wb_write(BASE + 8, 32'd3); m_irqen = 1'b1;
    fill_random(); send_frame(20, 1'b0, 0, 0);
    fill_random(); send_frame(96, 1'b0, 0, 0);
    check("irq_ferr", 32'(irq), 32'(m_irqen && (m_fifo.size() > 0 || m_ovf || m_ferr)));
    wb_read(BASE + 4, status_exp(0), "status_no_done");
    repeat (3) wb_read(BASE, m_pop(), "data_no_done");
    wb_write(BASE + 4, 32'h0002_0000); m_ferr = 1'b0;
    check("irq_cleared", 32'(irq), 32'(m_irqen && (m_fifo.size() > 0 || m_ovf || m_ferr)));

    // Overflow: 12 words into an 8-deep FIFO
    repeat (4) begin fill_random(); send_frame(96, 1'b1, 0, 0); end
    wb_read(BASE + 4, status_exp(0), "status_ovf");
    check("irq_ovf", 32'(irq), 32'd1);
    wb_read(BASE + 12, 32'(m_frames), "frames_ovf");
    repeat (8) wb_read(BASE, m_pop(), "data_ovf");
    wb_write(BASE + 4, 32'h0001_0000); m_ovf = 1'b0;
    wb_read(BASE + 4, status_exp(0), "status_ovf_clear");

    // Full FIFO: pop and push in the same cycle
    repeat (2) begin fill_random(); send_frame(96, 1'b1, 0, 0); end
    fill_random(); send_frame(96, 1'b1, 1, 95);
    wb_read(BASE + 4, status_exp(0), "status_same_cycle");
    repeat (8) wb_read(BASE, m_pop(), "data_same_cycle_drain");

    // Reset at bit 50, then a clean frame
    fill_random(); send_frame(96, 1'b1, 3, 49);
    wb_read(BASE + 4,  status_exp(0), "status_after_reset");
    wb_read(BASE + 12, 32'd0, "frames_after_reset");
    wb_write(BASE + 8, 32'd1); m_en = 1'b1;
    fill_random(); send_frame(96, 1'b1, 0, 0);
    repeat (3) wb_read(BASE, m_pop(), "data_post_reset");
    wb_read(BASE + 12, 32'(m_frames), "frames_post_reset");

    // Receiver disabled
    wb_write(BASE + 8, 32'd0); m_en = 1'b0; m_irqen = 1'b0;
    fill_random(); send_frame(96, 1'b1, 2, 20);
    wb_read(BASE + 4, status_exp(0), "status_disabled");
    wb_read(BASE, 32'd0, "data_empty");
    wb_read(BASE + 1, 32'd0, "odd_offset_read");
    wb_write(BASE + 1, 32'hFFFF_FFFF);
    wb_read(BASE + 8, 32'd0, "ctrl_after_odd_write");

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
